// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and constants for the 4-channel mux scanner.
//   state_t : scanner FSM states (IDLE, SETTLE, PUSH)
//   NCH     : number of mux channels
//   SELW    : width of the channel select
//   CNTW    : width of the dwell counter (DWELL up to 255)
package mux_scan_pkg;

  localparam int NCH  = 4;
  localparam int SELW = 2;
  localparam int CNTW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    PUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_next.sv
// mux_scan_next: combinational next-channel picker.
//   mask [3:0] in  : channel enables
//   cur  [1:0] in  : current channel
//   nxt  [1:0] out : next enabled channel strictly above cur, wrapping 3->0
//   wrap       out : 1 when the pick wrapped (nxt <= cur); 0 when mask is empty
// With cur=3 the result is the lowest set bit of mask.
module mux_scan_next
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] cur,
  output logic [SELW-1:0] nxt,
  output logic            wrap
);

  logic            found;
  logic [SELW-1:0] idx;

  // Walk the channels cur+1, cur+2, ... cur+NCH (mod NCH); the last step
  // revisits cur itself, which covers the single-channel case.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = SELW'((int'(cur) + k) % NCH);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    wrap = found && (nxt <= cur);
  end

endmodule

// File: rtl/mux_4ch_scanner.sv
// mux_4ch_scanner: drives the 2-bit select of a 4:1 mux, waits DWELL cycles
// for the mux output to settle, then offers (channel, bit) over valid/ready.
// Masked-off channels are skipped.
//   clk, rst_n (sync, active-low)
//   en         in  : scan enable (level)
//   mask[3:0]  in  : per-channel enable
//   sel[1:0]   out : mux select
//   y          in  : mux output
//   out_valid/out_ready, out_ch[1:0], out_bit : sample handshake
//   busy       out : FSM not in IDLE
//   snap[3:0]  out : last sampled bit per channel
//   frame_done out : one-cycle pulse when a handshake wraps the scan order
// Optional feature macro: MUX_SCAN_SNAP_EN enables snap/frame_done; when
// undefined both outputs are tied to 0.
module mux_4ch_scanner
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NCH-1:0]  mask,
  output logic [SELW-1:0] sel,
  input  logic            y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_ch,
  output logic            out_bit,
  output logic            busy,
  output logic [NCH-1:0]  snap,
  output logic            frame_done
);

  localparam logic [CNTW-1:0] DWELL_M1 = CNTW'(DWELL - 1);

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [SELW-1:0] cur;
  logic [SELW-1:0] nxt;
  logic            wrap;
  logic            hs;

  // From IDLE, asking for the successor of channel 3 yields the lowest set bit.
  assign cur  = (state == IDLE) ? SELW'(NCH - 1) : sel;
  assign hs   = (state == PUSH) && out_ready;
  assign busy = (state != IDLE);

  mux_scan_next u_next (
    .mask (mask),
    .cur  (cur),
    .nxt  (nxt),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_bit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && (mask != '0)) begin
            state <= SETTLE;
            sel   <= nxt;
            cnt   <= DWELL_M1;
          end
        end
        SETTLE: begin
          // Abort takes priority over a due sample.
          if (!en) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            out_bit   <= y;
            out_ch    <= sel;
            out_valid <= 1'b1;
            state     <= PUSH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PUSH: begin
          // A pending sample is never withdrawn; en only matters after the handshake.
          if (hs) begin
            out_valid <= 1'b0;
            if (en && (mask != '0)) begin
              state <= SETTLE;
              sel   <= nxt;
              cnt   <= DWELL_M1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUX_SCAN_SNAP_EN
  logic [NCH-1:0] snap_q;
  logic           fd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      fd_q <= hs && wrap;
      if (hs) snap_q[out_ch] <= out_bit;
    end
  end

  assign snap       = snap_q;
  assign frame_done = fd_q;
`else
  logic unused_wrap;
  assign unused_wrap = wrap;
  assign snap        = '0;
  assign frame_done  = 1'b0;
`endif

endmodule
